// File: rtl/merge_arb_ctrl_pkg.sv
// Shared types and helpers for the merge arbiter controller.
// Holds the FSM state encoding and the d_i channel-extraction helper.
package merge_arb_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    // Widest flattened data bus and widest single channel the helper supports.
    localparam int MAX_BUS = 1024;
    localparam int MAX_W   = 64;

    // Returns channel k of a flattened bus whose channels are n bits wide.
    // The result sits in the low n bits; the caller truncates to its width.
    function automatic logic [MAX_W-1:0] chan_data(input logic [MAX_BUS-1:0] bus,
                                                   input int k, input int n);
        return MAX_W'(bus >> (k * n));
    endfunction

endpackage

// File: rtl/merge_arb_ctrl_rr_pick.sv
// Combinational round-robin pick: rotate the request vector so ptr is at bit 0,
// find the first set bit, then rotate the offset back to an absolute index.
module merge_arb_ctrl_rr_pick #(
    parameter int NREQ = 2,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            vld,
    output logic [PW-1:0]   g
);

    logic [NREQ-1:0] rot;
    logic [PW-1:0]   off;
    logic [PW:0]     sum;

    always_comb begin
        rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            rot[i] = req[idx];
        end
    end

    // Descending scan so the lowest set offset wins.
    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) off = PW'(i);
    end

    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        g   = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];
    end

    assign vld = |req;

endmodule

// File: rtl/merge_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one four-phase bundled-data output
// channel between NREQ four-phase input channels; all outputs registered.
module merge_arb_ctrl
    import merge_arb_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int N    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   r_i,
    output logic [NREQ-1:0]   a_i,
    input  logic [NREQ*N-1:0] d_i,
    output logic              r_o,
    input  logic              a_o,
    output logic [N-1:0]      d_o,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   g_q, g_nxt;
    logic            r_o_nxt, busy_nxt;
    logic [NREQ-1:0] a_i_nxt, grant_nxt;
    logic [N-1:0]    d_o_nxt;
    logic            pick_vld;
    logic [PW-1:0]   pick_g;

    merge_arb_ctrl_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req (r_i),
        .ptr (ptr),
        .vld (pick_vld),
        .g   (pick_g)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            g_q   <= '0;
            r_o   <= 1'b0;
            a_i   <= '0;
            d_o   <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            g_q   <= g_nxt;
            r_o   <= r_o_nxt;
            a_i   <= a_i_nxt;
            d_o   <= d_o_nxt;
            grant <= grant_nxt;
            busy  <= busy_nxt;
        end
    end

    // A high a_o in IDLE is a stale consumer ack; never start a grant under it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_vld && !a_o) state_nxt = REQ;
            REQ:  if (a_o)              state_nxt = HOLD;
            HOLD: if (!r_i[g_q])        state_nxt = DROP;
            DROP: if (!a_o)             state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt   = ptr;
        g_nxt     = g_q;
        r_o_nxt   = r_o;
        a_i_nxt   = a_i;
        d_o_nxt   = d_o;
        grant_nxt = grant;
        case (state)
            IDLE: if (pick_vld && !a_o) begin
                g_nxt     = pick_g;
                grant_nxt = NREQ'(1) << pick_g;
                d_o_nxt   = N'(chan_data(MAX_BUS'(d_i), int'(pick_g), N));
                r_o_nxt   = 1'b1;
            end
            REQ:  if (a_o) a_i_nxt = grant;
            HOLD: if (!r_i[g_q]) r_o_nxt = 1'b0;
            DROP: if (!a_o) begin
                a_i_nxt   = '0;
                grant_nxt = '0;
                // Pointer moves only on completion, to the slot after the winner.
                ptr_nxt   = (g_q == PW'(NREQ - 1)) ? '0 : g_q + PW'(1);
            end
            default: ;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: doc/merge_arb_ctrl.md
Name: merge_arb_ctrl

Overview:
- Clocked round-robin arbiter and sequencer that shares one four-phase (return-to-zero) bundled-data output channel between NREQ four-phase input channels.
- It is the control companion of the team's async merge stage, which requires mutually exclusive input requests.
- This block enforces that exclusion, steers the granted requester's data to the output, and runs the full handshake on both sides.
- It sits wherever several producers feed one consumer channel in the synchronous domain.

Parameters:
- NREQ, 2, number of requesting input channels (≥2).
- N, 1, data width per channel in bits.

Ports:
- clk  in  1  clock; all inputs are sampled on the rising edge and are already synchronous to clk.
- rst  in  1  asynchronous, active-high reset.
- r_i  in  NREQ  per-channel request, four-phase.
- a_i  out  NREQ  per-channel acknowledge.
- d_i  in  NREQ*N  per-channel data; channel k occupies bits [k*N +: N]. Valid while r_i[k]=1 and a_i[k]=0.
- r_o  out  1  shared output request.
- a_o  in  1  shared output acknowledge.
- d_o  out  N  shared output data.
- grant  out  NREQ  one-hot owner of the output channel; zero when idle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, r_o=0, a_i=0, d_o=0, grant=0, busy=0, round-robin pointer ptr=0.
- The FSM has four states: IDLE, REQ, HOLD, DROP. g is the granted index.
- IDLE:
  - If any r_i is set and a_o=0, pick g = first set bit searching ptr, ptr+1, … mod NREQ.
  - Register d_o←d_i[g], grant←onehot(g), r_o←1, then go to REQ.
  - If a_o=1 while in IDLE (protocol violation), stay in IDLE and grant nothing.
- REQ: wait for a_o=1, then set a_i[g]←1 and go to HOLD.
- HOLD: wait for r_i[g]=0, then set r_o←0 and go to DROP.
- DROP: wait for a_o=0, then set a_i[g]←0, grant←0, ptr←(g+1) mod NREQ, and go to IDLE.
- Latency:
  - r_i[k] sampled high at edge t → r_o high after edge t.
  - a_o sampled high → a_i[g] high one edge later.
  - Same one-edge pattern for r_i[g] fall → r_o fall, and a_o fall → a_i[g] fall.
  - Minimum handshake is 4 cycles plus consumer and producer delays.
  - A new grant is possible on the edge after returning to IDLE, so back-to-back transfers have one IDLE cycle between them.
- d_o is latched at grant and held until the next grant. Upstream data may change once a_i[g] rises.
- Exclusion: at most one bit of grant and at most one bit of a_i is ever set. a_i[k]=1 implies grant[k]=1.
- Non-granted requesters:
  - A request arriving during a transfer waits; its a_i stays 0.
  - A non-granted r_i that drops before service is simply never granted (no latching of requests).
- Simultaneous requests are resolved by round-robin from ptr. With all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0.
- If r_i[g] falls while in REQ (protocol violation), ignore it and hold r_o until a_o rises. The fall is then seen in HOLD.
- rst asserted mid-transfer forces the reset values immediately. After rst falls, operation starts from IDLE with ptr=0. Recovering the external channels is the system's responsibility.
- ptr wraps modulo NREQ. It advances only on transfer completion, never on grant.

Decomposition:
- Shared package: the state enum {IDLE, REQ, HOLD, DROP}, and a function to extract channel k of the d_i bus.
- Sub-module rr_pick: purely combinational. Inputs are req[NREQ] and ptr; outputs are a valid flag and index g. It implements the rotate, find-first, un-rotate search.
- The FSM and registers live in merge_arb_ctrl.

Test Plan:
- Reset: hold rst=1, toggle r_i=2'b11 and a_o → r_o=0, a_i=0, grant=0, busy=0, d_o=0 throughout. Release rst with r_i=2'b01 and d_i[0]=8'hA5 (N=8) → r_o=1 and d_o=8'hA5 one edge later.
- Single full handshake on channel 1 with d_i[1]=8'h3C; consumer acks 2 cycles after r_o; producer drops r_i 1 cycle after a_i.
  - Sequence: r_o↑, a_i[1]↑, r_o↓, a_i[1]↓ in order.
  - d_o=8'h3C from grant onward; grant=2'b10 during the transfer; ptr ends at 0.
- Contention, NREQ=2: r_i=2'b11 held, each producer re-requesting immediately → grants alternate 0,1,0,1 over 4 transfers. Grant and a_i are never multi-hot.
- NREQ=4, r_i=4'b1010 after one completed transfer on channel 1 (ptr=2) → channel 3 is granted, then channel 1 next.
- a_o stuck at 1 in IDLE with r_i[0]=1 → no grant and r_o stays 0. Release a_o → grant on the next edge.
- Reset mid-HOLD (a_i[0]=1, r_o=1): assert rst asynchronously between edges → r_o, a_i, grant and busy go to 0 immediately, without waiting for a clock edge.
